// File: rtl/truth_table_pkg.sv
// Shared types and sizes for the truth-table sweeper: FSM states and
// vector/counter widths used by the top, the interface and the tracker.
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_VEC = 16;
  localparam int IDX_W = 4;
  localparam int CNT_W = 5;

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bundle between lab control / function block (master side) and the
// sweeper (slave side).
interface truth_table_sweeper_if;
  import truth_table_pkg::*;

  logic             start;
  logic [N_VEC-1:0] expected;
  logic [IDX_W-1:0] dut_in;
  logic             dut_f;
  logic             busy;
  logic             done;
  logic [N_VEC-1:0] signature;
  logic             match;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [IDX_W-1:0] first_fail;

  modport master (
    output start, expected, dut_f,
    input  dut_in, busy, done, signature, match, mismatch_cnt, first_fail
  );

  modport slave (
    input  start, expected, dut_f,
    output dut_in, busy, done, signature, match, mismatch_cnt, first_fail
  );

endinterface

// File: rtl/tt_compare_tracker.sv
// Counts mismatching captures during a sweep and remembers the index of
// the first one. Cleared when a new sweep is accepted.
module tt_compare_tracker
  import truth_table_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             capture,
  input  logic [IDX_W-1:0] idx,
  input  logic             f,
  input  logic             exp_bit,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic [IDX_W-1:0] first_fail
);

  logic [CNT_W-1:0] cnt_reg;
  logic [IDX_W-1:0] first_reg;
  logic             miss;

  assign miss = capture && (f != exp_bit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      first_reg <= '0;
    end else if (clear) begin
      cnt_reg   <= '0;
      first_reg <= '0;
    end else if (miss) begin
      // a zero count means no earlier mismatch in this sweep
      if (cnt_reg == '0) begin
        first_reg <= idx;
      end
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign mismatch_cnt = cnt_reg;
  assign first_fail   = first_reg;

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a 4-input function block through all 16 vectors, holding each for
// SETTLE_CYCLES+1 clocks, and captures f into a signature checked against expected.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input logic                  clk,
  input logic                  rst_n,
  truth_table_sweeper_if.slave bus
);

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_VEC - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [IDX_W-1:0] idx_reg;
  logic [7:0]       settle_reg;
  logic [N_VEC-1:0] expected_q;
  logic [N_VEC-1:0] signature_reg;
  logic             match_reg;
  logic             accept;
  logic             capture;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [IDX_W-1:0] first_fail;

  assign accept  = (state_reg == IDLE) && bus.start;
  assign capture = (state_reg == RUN) && (settle_reg == SETTLE_LAST);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (capture && (idx_reg == IDX_LAST)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg       <= '0;
      settle_reg    <= '0;
      expected_q    <= '0;
      signature_reg <= '0;
      match_reg     <= 1'b0;
    end else if (accept) begin
      expected_q    <= bus.expected;
      idx_reg       <= '0;
      settle_reg    <= '0;
      signature_reg <= '0;
      match_reg     <= 1'b0;
    end else if (state_reg == RUN) begin
      if (capture) begin
        // idx wraps 15->0 on the same edge that leaves RUN
        signature_reg[idx_reg] <= bus.dut_f;
        idx_reg                <= idx_reg + 1'b1;
        settle_reg             <= '0;
      end else begin
        settle_reg <= settle_reg + 8'd1;
      end
    end else if (state_reg == DONE) begin
      match_reg <= (mismatch_cnt == '0);
    end
  end

  tt_compare_tracker u_tracker (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (accept),
    .capture      (capture),
    .idx          (idx_reg),
    .f            (bus.dut_f),
    .exp_bit      (expected_q[idx_reg]),
    .mismatch_cnt (mismatch_cnt),
    .first_fail   (first_fail)
  );

  // match is derived live during the done cycle, then held in match_reg
  assign bus.busy         = (state_reg == RUN);
  assign bus.done         = (state_reg == DONE);
  assign bus.dut_in       = (state_reg == RUN) ? idx_reg : '0;
  assign bus.signature    = signature_reg;
  assign bus.match        = (state_reg == DONE) ? (mismatch_cnt == '0) : match_reg;
  assign bus.mismatch_cnt = mismatch_cnt;
  assign bus.first_fail   = first_fail;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: two sweepers (S=2 and S=0) drive a model of f=(A&B)|C;
// each step is checked with an immediate assertion.
module tb_truth_table_sweeper;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  truth_table_sweeper_if if2 ();
  truth_table_sweeper_if if0 ();

  assign if2.dut_f = (if2.dut_in[3] & if2.dut_in[2]) | if2.dut_in[1];
  assign if0.dut_f = (if0.dut_in[3] & if0.dut_in[2]) | if0.dut_in[1];

  truth_table_sweeper #(.SETTLE_CYCLES(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.slave)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_results2(input string tag, input logic [15:0] sig_e, input logic match_e,
                                input logic [4:0] cnt_e, input logic [3:0] ff_e);
    check({tag, "_sig"},   32'(if2.signature),    32'(sig_e));
    check({tag, "_match"}, 32'(if2.match),        32'(match_e));
    check({tag, "_cnt"},   32'(if2.mismatch_cnt), 32'(cnt_e));
    check({tag, "_ff"},    32'(if2.first_fail),   32'(ff_e));
  endtask

  // Full sweep on the S=2 instance; optional start re-pulse while idx=7.
  task automatic sweep2(input logic [15:0] exp, input bit repulse, input logic [15:0] sig_e,
                        input logic match_e, input logic [4:0] cnt_e, input logic [3:0] ff_e);
    @(negedge clk);
    if2.expected = exp;
    if2.start    = 1'b1;
    @(posedge clk);
    #1 if2.start = 1'b0;
    for (int e = 1; e < 48; e++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("s2_dut_in_e%0d", e), 32'(if2.dut_in), 32'(e / 3));
      check($sformatf("s2_busy_e%0d", e),   32'(if2.busy),   32'd1);
      check($sformatf("s2_done_e%0d", e),   32'(if2.done),   32'd0);
      if (repulse && e == 21) begin
        if2.start    = 1'b1;
        if2.expected = 16'h0000;
      end
      if (repulse && e == 22) begin
        if2.start = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("s2_done_at_48",   32'(if2.done),   32'd1);
    check("s2_busy_at_48",   32'(if2.busy),   32'd0);
    check("s2_dut_in_at_48", 32'(if2.dut_in), 32'd0);
    check_results2("s2_done_cycle", sig_e, match_e, cnt_e, ff_e);
    @(posedge clk);
    @(negedge clk);
    check("s2_done_after", 32'(if2.done), 32'd0);
    check("s2_busy_after", 32'(if2.busy), 32'd0);
    check_results2("s2_hold", sig_e, match_e, cnt_e, ff_e);
    $display("sweep S=2 expected=%h signature=%h match=%0d mismatch_cnt=%0d first_fail=%0d",
             exp, if2.signature, if2.match, if2.mismatch_cnt, if2.first_fail);
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    if2.start    = 1'b0;
    if2.expected = 16'h0000;
    if0.start    = 1'b0;
    if0.expected = 16'h0000;
    #12;
    check("rst_busy",   32'(if2.busy),   32'd0);
    check("rst_done",   32'(if2.done),   32'd0);
    check("rst_dut_in", 32'(if2.dut_in), 32'd0);
    check_results2("rst", 16'h0000, 1'b0, 5'd0, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // exact match, two mismatches, all mismatching, mid-sweep start/expected churn
    sweep2(16'hFCCC, 1'b0, 16'hFCCC, 1'b1, 5'd0,  4'd0);
    sweep2(16'hFDEC, 1'b0, 16'hFCCC, 1'b0, 5'd2,  4'd5);
    sweep2(16'h0333, 1'b0, 16'hFCCC, 1'b0, 5'd16, 4'd0);
    sweep2(16'hFCCC, 1'b1, 16'hFCCC, 1'b1, 5'd0,  4'd0);

    // asynchronous reset while idx=9
    @(negedge clk);
    if2.expected = 16'hFDEC;
    if2.start    = 1'b1;
    @(posedge clk);
    #1 if2.start = 1'b0;
    repeat (28) @(posedge clk);
    @(negedge clk);
    check("mid_dut_in_9", 32'(if2.dut_in), 32'd9);
    check("mid_busy",     32'(if2.busy),   32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy",   32'(if2.busy),   32'd0);
    check("arst_done",   32'(if2.done),   32'd0);
    check("arst_dut_in", 32'(if2.dut_in), 32'd0);
    check_results2("arst", 16'h0000, 1'b0, 5'd0, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("post_rst_busy",   32'(if2.busy),   32'd0);
    check("post_rst_done",   32'(if2.done),   32'd0);
    check("post_rst_dut_in", 32'(if2.dut_in), 32'd0);
    check("post_rst_sig",    32'(if2.signature), 32'd0);
    $display("reset mid-sweep: busy=%0d dut_in=%0d signature=%h", if2.busy, if2.dut_in, if2.signature);

    // S=0: one vector per clock, then start held through DONE for a back-to-back sweep
    @(negedge clk);
    if0.expected = 16'hFCCC;
    if0.start    = 1'b1;
    @(posedge clk);
    #1 if0.start = 1'b0;
    for (int e = 1; e < 16; e++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("s0_dut_in_e%0d", e), 32'(if0.dut_in), 32'(e));
      check($sformatf("s0_busy_e%0d", e),   32'(if0.busy),   32'd1);
    end
    @(posedge clk);
    @(negedge clk);
    check("s0_done_at_16",  32'(if0.done),         32'd1);
    check("s0_busy_at_16",  32'(if0.busy),         32'd0);
    check("s0_sig_a",       32'(if0.signature),    32'hFCCC);
    check("s0_match_a",     32'(if0.match),        32'd1);
    check("s0_cnt_a",       32'(if0.mismatch_cnt), 32'd0);
    check("s0_ff_a",        32'(if0.first_fail),   32'd0);
    $display("sweep S=0 #1 signature=%h match=%0d mismatch_cnt=%0d", if0.signature, if0.match, if0.mismatch_cnt);
    if0.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("s0_idle_busy",  32'(if0.busy),  32'd0);
    check("s0_idle_done",  32'(if0.done),  32'd0);
    check("s0_idle_match", 32'(if0.match), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("s0_restart_busy",   32'(if0.busy),         32'd1);
    check("s0_restart_dut_in", 32'(if0.dut_in),       32'd0);
    check("s0_restart_sig",    32'(if0.signature),    32'd0);
    check("s0_restart_match",  32'(if0.match),        32'd0);
    if0.start = 1'b0;
    for (int e = 19; e < 34; e++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("s0b_dut_in_e%0d", e), 32'(if0.dut_in), 32'(e - 18));
    end
    @(posedge clk);
    @(negedge clk);
    check("s0_done_b",  32'(if0.done),         32'd1);
    check("s0_sig_b",   32'(if0.signature),    32'hFCCC);
    check("s0_match_b", 32'(if0.match),        32'd1);
    check("s0_cnt_b",   32'(if0.mismatch_cnt), 32'd0);
    check("s0_ff_b",    32'(if0.first_fail),   32'd0);
    $display("sweep S=0 #2 signature=%h match=%0d mismatch_cnt=%0d", if0.signature, if0.match, if0.mismatch_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
